// File: rtl/speed_level_ctrl.sv
// Speed level controller: pause toggle plus up/down level stepping
// with optional wrap-around and held-button auto-repeat.
module speed_level_ctrl #(
    parameter int NUM_LEVELS    = 3,
    parameter int INIT_LEVEL    = 1,
    parameter bit WRAP          = 1'b0,
    parameter int REPEAT_CYCLES = 0,
    localparam int LVL_W = (NUM_LEVELS <= 2) ? 1 : $clog2(NUM_LEVELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             speedup,
    input  logic             speeddown,
    output logic [LVL_W-1:0] level,
    output logic             paused,
    output logic             changed,
    output logic             at_max,
    output logic             at_min
);

    localparam int RC_W = (REPEAT_CYCLES < 1) ? 1
                        : $clog2(REPEAT_CYCLES + 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REPEAT_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LVL_W-1:0] LVL_INIT = LVL_W'(INIT_LEVEL);
    localparam bit               REP_EN   = (REPEAT_CYCLES > 0);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LVL_W-1:0]  r_level;
    logic [LVL_W-1:0]  w_level_nxt;
    logic [RC_W-1:0]   r_rep;
    logic [RC_W-1:0]   w_rep_nxt;
    logic              r_rep_act;
    logic              w_rep_act_nxt;
    logic              r_changed;
    logic              r_pause_prev;
    logic              r_up_prev;
    logic              r_dn_prev;
    logic              w_pause_rise;
    logic              w_up_rise;
    logic              w_dn_rise;
    logic              w_step_up;
    logic              w_step_dn;

    assign w_pause_rise = pause & ~r_pause_prev;
    assign w_up_rise    = speedup & ~r_up_prev;
    assign w_dn_rise    = speeddown & ~r_dn_prev;

    // r_rep_act marks a repeat run started by a real press, so a button
    // held through reset or pause never begins repeating on its own.
    always_comb begin
        w_state_nxt   = r_state;
        w_rep_nxt     = r_rep;
        w_rep_act_nxt = r_rep_act;
        w_step_up     = 1'b0;
        w_step_dn     = 1'b0;
        if (w_pause_rise) begin
            w_state_nxt   = (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
            w_rep_nxt     = '0;
            w_rep_act_nxt = 1'b0;
        end else if (r_state == ST_PAUSED) begin
            w_rep_nxt     = '0;
            w_rep_act_nxt = 1'b0;
        end else if (speedup && speeddown) begin
            w_rep_nxt     = '0;
            w_rep_act_nxt = 1'b0;
        end else if (w_up_rise || w_dn_rise) begin
            w_step_up     = w_up_rise;
            w_step_dn     = w_dn_rise;
            w_rep_nxt     = '0;
            w_rep_act_nxt = REP_EN;
        end else if ((speedup || speeddown) && r_rep_act) begin
            if (r_rep == RC_LAST) begin
                w_step_up = speedup;
                w_step_dn = speeddown;
                w_rep_nxt = '0;
            end else begin
                w_rep_nxt = r_rep + 1'b1;
            end
        end else begin
            w_rep_nxt     = '0;
            w_rep_act_nxt = 1'b0;
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        unique case (1'b1)
            w_step_up: begin
                if (r_level == LVL_MAX) begin
                    w_level_nxt = WRAP ? '0 : r_level;
                end else begin
                    w_level_nxt = r_level + 1'b1;
                end
            end
            w_step_dn: begin
                if (r_level == '0) begin
                    w_level_nxt = WRAP ? LVL_MAX : r_level;
                end else begin
                    w_level_nxt = r_level - 1'b1;
                end
            end
            default: w_level_nxt = r_level;
        endcase
    end

    // Prev flops reset high: a button held through reset is not a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_level      <= LVL_INIT;
            r_rep        <= '0;
            r_rep_act    <= 1'b0;
            r_changed    <= 1'b0;
            r_pause_prev <= 1'b1;
            r_up_prev    <= 1'b1;
            r_dn_prev    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_rep        <= w_rep_nxt;
            r_rep_act    <= w_rep_act_nxt;
            r_changed    <= (w_level_nxt != r_level) ||
                            (w_state_nxt != r_state);
            r_pause_prev <= pause;
            r_up_prev    <= speedup;
            r_dn_prev    <= speeddown;
        end
    end

    assign level   = r_level;
    assign paused  = (r_state == ST_PAUSED);
    assign changed = r_changed;
    assign at_max  = (r_level == LVL_MAX);
    assign at_min  = (r_level == '0);

endmodule

// File: tb/tb_speed_level_ctrl.sv
// Directed bench: saturating (u0) and wrapping (u1) instances share stimulus.
module tb_speed_level_ctrl;

    logic       clk;
    logic       rst;
    logic       pause;
    logic       speedup;
    logic       speeddown;
    logic [2:0] lvl0;
    logic [2:0] lvl1;
    logic       p0;
    logic       p1;
    logic       c0;
    logic       c1;
    logic       mx0;
    logic       mn0;
    logic       mx1;
    logic       mn1;
    int         n_checks;
    int         n_errors;

    speed_level_ctrl #(
        .NUM_LEVELS(5), .INIT_LEVEL(2), .WRAP(1'b0), .REPEAT_CYCLES(4)
    ) u0 (
        .clk(clk), .rst(rst), .pause(pause), .speedup(speedup),
        .speeddown(speeddown), .level(lvl0), .paused(p0),
        .changed(c0), .at_max(mx0), .at_min(mn0)
    );

    speed_level_ctrl #(
        .NUM_LEVELS(5), .INIT_LEVEL(2), .WRAP(1'b1), .REPEAT_CYCLES(4)
    ) u1 (
        .clk(clk), .rst(rst), .pause(pause), .speedup(speedup),
        .speeddown(speeddown), .level(lvl1), .paused(p1),
        .changed(c1), .at_max(mx1), .at_min(mn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk(input string tag, input int e0, input int e1,
                       input int ep, input int ec0, input int ec1);
        check({tag, ".lvl0"}, 32'(lvl0), e0);
        check({tag, ".lvl1"}, 32'(lvl1), e1);
        check({tag, ".p0"}, 32'(p0), ep);
        check({tag, ".p1"}, 32'(p1), ep);
        check({tag, ".c0"}, 32'(c0), ec0);
        check({tag, ".c1"}, 32'(c1), ec1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        pause     = 1'b0;
        speedup   = 1'b0;
        speeddown = 1'b0;
        tick();
        tick();
        chk("rst", 2, 2, 0, 0, 0);
        check("rst.amax", 32'(mx0), 0);
        check("rst.amin", 32'(mn0), 0);
        rst = 1'b0;
        tick();
        chk("idle", 2, 2, 0, 0, 0);

        speedup = 1'b1; tick(); chk("up1", 3, 3, 0, 1, 1);
        speedup = 1'b0; tick(); chk("up1r", 3, 3, 0, 0, 0);
        speedup = 1'b1; tick(); chk("up2", 4, 4, 0, 1, 1);
        speedup = 1'b0; tick(); chk("up2r", 4, 4, 0, 0, 0);
        speedup = 1'b1; tick(); chk("up3", 4, 0, 0, 0, 1);
        check("up3.amax0", 32'(mx0), 1);
        check("up3.amin1", 32'(mn1), 1);
        speedup = 1'b0; tick(); chk("up3r", 4, 0, 0, 0, 0);

        speeddown = 1'b1; tick(); chk("wdn", 3, 4, 0, 1, 1);
        check("wdn.amax1", 32'(mx1), 1);
        speeddown = 1'b0; tick();
        speedup = 1'b1; tick(); chk("wup", 4, 0, 0, 1, 1);
        speedup = 1'b0; tick();

        for (int i = 0; i < 4; i++) begin
            speeddown = 1'b1; tick();
            speeddown = 1'b0; tick();
        end
        chk("dn4", 0, 1, 0, 0, 0);
        check("dn4.amin0", 32'(mn0), 1);

        speedup = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("rep%0d", k), 1 + k / 4, 2 + k / 4, 0,
                int'(k % 4 == 0), int'(k % 4 == 0));
        end
        speedup = 1'b0; tick(); chk("reprel", 3, 4, 0, 0, 0);
        tick(); chk("reprel2", 3, 4, 0, 0, 0);

        speeddown = 1'b1; tick(); chk("dn", 2, 3, 0, 1, 1);
        speeddown = 1'b0; tick();
        pause = 1'b1; tick(); chk("pz", 2, 3, 1, 1, 1);
        pause = 1'b0; tick(); chk("pzr", 2, 3, 1, 0, 0);
        speedup = 1'b1;
        repeat (6) tick();
        chk("pzup", 2, 3, 1, 0, 0);
        speedup = 1'b0; tick();
        pause = 1'b1; tick(); chk("unpz", 2, 3, 0, 1, 1);
        pause = 1'b0; tick(); chk("unpzr", 2, 3, 0, 0, 0);

        pause = 1'b1; speedup = 1'b1; tick();
        chk("pzup_same", 2, 3, 1, 1, 1);
        pause = 1'b0; speedup = 1'b0; tick();
        chk("pzup_rel", 2, 3, 1, 0, 0);
        pause = 1'b1; tick(); chk("unpz2", 2, 3, 0, 1, 1);
        pause = 1'b0; tick();
        speedup = 1'b1; speeddown = 1'b1; tick();
        chk("both", 2, 3, 0, 0, 0);
        speedup = 1'b0; speeddown = 1'b0; tick();
        speeddown = 1'b1; tick(); chk("dnh", 1, 2, 0, 1, 1);
        speedup = 1'b1; tick(); chk("up_dnheld", 1, 2, 0, 0, 0);
        repeat (5) tick();
        chk("bothheld", 1, 2, 0, 0, 0);
        speedup = 1'b0;
        repeat (6) tick();
        chk("dn_norep", 1, 2, 0, 0, 0);
        speeddown = 1'b0; tick();

        rst = 1'b1; speedup = 1'b1; tick();
        chk("rsthold", 2, 2, 0, 0, 0);
        rst = 1'b0;
        repeat (6) tick();
        chk("heldrel", 2, 2, 0, 0, 0);
        speedup = 1'b0; tick(); chk("heldrel2", 2, 2, 0, 0, 0);
        speedup = 1'b1; tick(); chk("repress", 3, 3, 0, 1, 1);
        repeat (4) tick();
        chk("hold4", 4, 4, 0, 1, 1);
        tick(); chk("hold5", 4, 4, 0, 0, 0);
        #3 rst = 1'b1;
        #1 chk("asyncrst", 2, 2, 0, 0, 0);
        tick();
        rst = 1'b0; speedup = 1'b0;
        tick(); chk("postrst", 2, 2, 0, 0, 0);
        tick(); chk("postrst2", 2, 2, 0, 0, 0);

        pause = 1'b1; tick(); chk("pz3", 2, 2, 1, 1, 1);
        pause = 1'b0; rst = 1'b1; tick();
        rst = 1'b0; tick(); chk("pzrst", 2, 2, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/speed_level_ctrl.md
SPEED_LEVEL_CTRL -- requirements
Module: speed_level_ctrl

Interface
REQ-001 Parameter NUM_LEVELS, default 3, number of speed levels, legal range 2..16.
REQ-002 Parameter INIT_LEVEL, default 1, level after reset, legal range 0..NUM_LEVELS-1.
REQ-003 Parameter WRAP, default 0; 0 = saturate at the level ends, 1 = wrap around.
REQ-004 Parameter REPEAT_CYCLES, default 0; held-button auto-repeat period in clocks, 0 = auto-repeat disabled.
REQ-005 Localparam LVL_W = max(1, ceil(log2(NUM_LEVELS))).
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, asynchronous assert, active-high.
REQ-008 pause  in  1  synchronous, debounced, high while pressed.
REQ-009 speedup  in  1  synchronous, debounced, high while pressed.
REQ-010 speeddown  in  1  synchronous, debounced, high while pressed.
REQ-011 level  out  LVL_W  current speed level (registered).
REQ-012 paused  out  1  high in PAUSED state (registered).
REQ-013 changed  out  1  one-cycle pulse on any level or paused change (registered).
REQ-014 at_max / at_min  out  1 each  combinational decodes: level==NUM_LEVELS-1 / level==0.

Function
REQ-015 Each button has a registered previous-value flop; a press event (rise) is in & ~prev, evaluated in the same cycle.
REQ-016 FSM has two states, RUN and PAUSED; level is held in a separate register that is preserved across PAUSED.
REQ-017 In RUN, a pause rise moves the FSM to PAUSED; in PAUSED, a pause rise moves it to RUN. Level is unchanged by either transition.
REQ-018 Priority per cycle: pause rise first, then speed events; in any cycle with a pause rise, speed events are ignored.
REQ-019 In PAUSED, speedup and speeddown are ignored and the repeat counter is held at 0.
REQ-020 In RUN, a speed step occurs on a speedup rise (step +1) or a speeddown rise (step -1) when the other button is low.
REQ-021 Simultaneous rises, or either rise while the other button is held high, produce no step and clear the repeat counter.
REQ-022 Step timing: the step appears on level at the same clock edge that registers the rise, i.e. one cycle after the input goes high.
REQ-023 WRAP=0: +1 at NUM_LEVELS-1 and -1 at 0 produce no change and no changed pulse.
REQ-024 WRAP=1: +1 at NUM_LEVELS-1 gives 0 and -1 at 0 gives NUM_LEVELS-1, each with a changed pulse.
REQ-025 Auto-repeat (REPEAT_CYCLES>0, RUN, exactly one of speedup/speeddown high): with the first step at edge t, further steps occur at t+R, t+2R, ... (R = REPEAT_CYCLES) while the button stays high.
REQ-026 The repeat counter clears on any rise, on release, when both buttons are high, and on entry to or exit from PAUSED.
REQ-027 The repeat counter width is ceil(log2(REPEAT_CYCLES+1)) and it never wraps.
REQ-028 changed is high for exactly the one cycle following each edge at which level or paused changed.
REQ-029 level never holds a value >= NUM_LEVELS.

Reset
REQ-030 While rst is high: level=INIT_LEVEL, FSM=RUN, paused=0, changed=0, repeat counter=0, all prev flops=1.
REQ-031 Prev flops reset to 1 so that a button held through reset release causes no event until it is released and pressed again.
REQ-032 rst asserted mid-repeat or mid-pause aborts the operation immediately; no step or changed pulse follows release of reset.

Verification (NUM_LEVELS=5, INIT_LEVEL=2, REPEAT_CYCLES=4 unless stated)
REQ-033 Reset, then speedup pulses 1 cycle x3 (WRAP=0) -> level 3, 4, 4; changed pulses twice only; at_max=1.
REQ-034 WRAP=1: from level 0, speeddown pulse -> level 4 with changed; speedup pulse -> level 0.
REQ-035 speedup held 10 cycles from level 0 -> steps at t, t+4, t+8; level 3 after release, with no step on release.
REQ-036 From level 2, pause pulse -> paused=1; speedup pulse -> level stays 2; pause pulse -> paused=0, level 2; changed on both toggles only.
REQ-037 pause and speedup rise in the same cycle -> paused=1, level unchanged; speedup and speeddown rise together -> no change.
REQ-038 Hold speedup across rst deassertion -> no step until release and re-press; rst pulse mid-hold at level 4 -> level 2.
